// File: rtl/kpn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kpn_pkg
// Description : Shared definitions for the KPN token-processing nodes:
//               token width, node FSM encoding and saturation limits.
// Revision    : 1.0 - initial release
// ============================================================================
package kpn_pkg;

  // Token width used across the KPN fabric FIFOs
  localparam int KPN_WORD_W = 16;

  // Node FSM encoding: consult flags, strobe read, capture data, strobe write
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    READ    = 2'b01,
    CAPTURE = 2'b10,
    WRITE   = 2'b11
  } kpn_state_t;

  // Clamp values for a KPN_WORD_W-wide result
  localparam logic [KPN_WORD_W-1:0] KPN_SAT_SMAX = 16'h7FFF;
  localparam logic [KPN_WORD_W-1:0] KPN_SAT_SMIN = 16'h8000;
  localparam logic [KPN_WORD_W-1:0] KPN_SAT_UMAX = 16'hFFFF;

endpackage : kpn_pkg
`default_nettype wire

// File: rtl/kpn_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : kpn_sat_add
// Description : Combinational B-bit adder with overflow detection. The sum is
//               formed in B+1 bits (sign- or zero-extended operands); when
//               the KPN_ADD_SAT_EN macro is defined an overflowing result is
//               clamped, otherwise it wraps modulo 2^B.
// Config      : KPN_ADD_SAT_EN - enable saturation on overflow
// Revision    : 1.0 - initial release
// ============================================================================
module kpn_sat_add
  import kpn_pkg::*;
#(
  parameter int B      = KPN_WORD_W,
  parameter bit SIGNED = 1'b1
) (
  input  logic [B-1:0] i_a,
  input  logic [B-1:0] i_b,
  output logic [B-1:0] o_sum,
  output logic         o_ovf
);

  logic [B:0] w_sum;

  // With sign-extended operands, bit B is the true sign of the exact sum, so
  // overflow is a disagreement between bit B and bit B-1.
  generate
    if (SIGNED) begin : g_signed
      assign w_sum = {i_a[B-1], i_a} + {i_b[B-1], i_b};
      assign o_ovf = w_sum[B] ^ w_sum[B-1];
    end else begin : g_unsigned
      assign w_sum = {1'b0, i_a} + {1'b0, i_b};
      assign o_ovf = w_sum[B];
    end
  endgenerate

`ifdef KPN_ADD_SAT_EN
  logic [B-1:0] w_clamp;

  // Direction of a signed overflow follows the exact sum's sign (bit B)
  generate
    if (SIGNED) begin : g_clamp_signed
      assign w_clamp = w_sum[B] ? {1'b1, {(B-1){1'b0}}} : {1'b0, {(B-1){1'b1}}};
    end else begin : g_clamp_unsigned
      assign w_clamp = {B{1'b1}};
    end
  endgenerate

  assign o_sum = o_ovf ? w_clamp : w_sum[B-1:0];
`else
  assign o_sum = w_sum[B-1:0];
`endif

endmodule : kpn_sat_add
`default_nettype wire

// File: rtl/kpn_add_node.sv
`default_nettype none
// ============================================================================
// Module      : kpn_add_node
// Description : KPN compute node. Waits until both input FIFOs hold a token
//               and the output FIFO has room, pops one token from each (the
//               FIFOs return data one cycle after the read strobe), adds
//               them and pushes the sum. All outputs are registered.
// Config      : KPN_ADD_SAT_EN - saturate the sum on overflow (in kpn_sat_add)
// Revision    : 1.0 - initial release
// ============================================================================
module kpn_add_node
  import kpn_pkg::*;
#(
  parameter int B      = KPN_WORD_W,
  parameter bit SIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         empty_a,
  input  logic         empty_b,
  input  logic [B-1:0] data_a,
  input  logic [B-1:0] data_b,
  input  logic         full_out,
  output logic         rd_a,
  output logic         rd_b,
  output logic         wr_out,
  output logic [B-1:0] data_out,
  output logic [15:0]  token_cnt,
  output logic         ovf
);

  kpn_state_t   r_state;
  logic         r_rd;
  logic         r_wr;
  logic [B-1:0] r_data;
  logic [15:0]  r_cnt;
  logic         r_ovf;

  logic [B-1:0] w_sum;
  logic         w_ovf;

  kpn_sat_add #(
    .B      (B),
    .SIGNED (SIGNED)
  ) u_add (
    .i_a   (data_a),
    .i_b   (data_b),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  // Node FSM; strobes are registered alongside the state that owns them.
  // This node is the only reader/writer of its FIFOs, so flags are checked
  // once in IDLE and cannot change against us before WRITE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wr <= 1'b0;
          if (!empty_a && !empty_b && !full_out) begin
            r_state <= READ;
            r_rd    <= 1'b1;
          end
        end
        READ: begin
          r_state <= CAPTURE;
          r_rd    <= 1'b0;
        end
        CAPTURE: begin
          // FIFO read data is valid now, one cycle after the strobe
          r_state <= WRITE;
          r_data  <= w_sum;
          r_ovf   <= r_ovf | w_ovf;
          r_wr    <= 1'b1;
        end
        WRITE: begin
          r_state <= IDLE;
          r_wr    <= 1'b0;
          r_cnt   <= r_cnt + 16'd1;
        end
        default: begin
          r_state <= IDLE;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end

  assign rd_a      = r_rd;
  assign rd_b      = r_rd;
  assign wr_out    = r_wr;
  assign data_out  = r_data;
  assign token_cnt = r_cnt;
  assign ovf       = r_ovf;

endmodule : kpn_add_node
`default_nettype wire

// File: tb/tb_kpn_add_node.sv
`default_nettype none
// ============================================================================
// Module      : tb_kpn_add_node
// Description : Self-checking bench for kpn_add_node. Behavioural FIFO models
//               feed the node; a scoreboard pairs tokens in push order and
//               computes the expected sum with plain integer arithmetic.
//               Honors KPN_ADD_SAT_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kpn_add_node;

  localparam int B      = 16;
  localparam bit SIGNED = 1'b1;
  localparam int N_RAND = 150;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         empty_a = 1'b1;
  logic         empty_b = 1'b1;
  logic [B-1:0] data_a = '0;
  logic [B-1:0] data_b = '0;
  logic         full_out = 1'b0;
  logic         rd_a, rd_b, wr_out, ovf;
  logic [B-1:0] data_out;
  logic [15:0]  token_cnt;

  kpn_add_node #(.B(B), .SIGNED(SIGNED)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .empty_a   (empty_a),
    .empty_b   (empty_b),
    .data_a    (data_a),
    .data_b    (data_b),
    .full_out  (full_out),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .wr_out    (wr_out),
    .data_out  (data_out),
    .token_cnt (token_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  logic [B-1:0] qa[$], qb[$];   // FIFO contents
  logic [B-1:0] ma[$], mb[$];   // scoreboard copies of pushed tokens
  logic [B-1:0] outs[$];
  int           wr_times[$];
  int           cyc = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  logic         exp_ovf = 1'b0;
  logic         prev_rd = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  function automatic void fail_event(input string name);
    n_total++;
    $display("FAIL %s: got event, expected none", name);
  endfunction

  // Reference: exact integer sum, then wrap or clamp. Bit 16 = overflow.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int          s;
    logic        o;
    logic [31:0] sv;
    logic [15:0] r;
    if (SIGNED) begin
      s = int'($signed(a)) + int'($signed(b));
      o = (s > 32767) || (s < -32768);
    end else begin
      s = int'(a) + int'(b);
      o = (s > 65535);
    end
    sv = s;
    r  = sv[15:0];
`ifdef KPN_ADD_SAT_EN
    if (o) r = SIGNED ? ((s > 0) ? 16'h7FFF : 16'h8000) : 16'hFFFF;
`endif
    return {o, r};
  endfunction

  // Cycle counter and FIFO read ports with one-cycle registered latency
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && rd_a) begin
      if (qa.size() > 0) data_a <= qa.pop_front();
      else fail_event("fifo_a_underflow");
    end
    if (reset_n && rd_b) begin
      if (qb.size() > 0) data_b <= qb.pop_front();
      else fail_event("fifo_b_underflow");
    end
  end

  // FIFO status flags refreshed mid-cycle after pushes and pops settle
  always @(negedge clk) begin
    empty_a <= (qa.size() == 0);
    empty_b <= (qb.size() == 0);
  end

  // Output monitor and scoreboard
  always @(negedge clk) begin
    logic [16:0] r;
    logic [15:0] a, b;
    if (reset_n) begin
      if (rd_a !== rd_b) fail_event("rd_pair_mismatch");
      if (rd_a && prev_rd) fail_event("rd_longer_than_one_cycle");
      if (rd_a) rd_cnt++;
      prev_rd = rd_a;
      if (wr_out) begin
        wr_cnt++;
        wr_times.push_back(cyc);
        outs.push_back(data_out);
        if (ma.size() == 0 || mb.size() == 0) begin
          fail_event("write_without_token_pair");
        end else begin
          a = ma.pop_front();
          b = mb.pop_front();
          r = ref_add(a, b);
          exp_ovf = exp_ovf | r[16];
          check("sb_data_out", 32'(data_out), 32'(r[15:0]));
          check("sb_ovf", 32'(ovf), 32'(exp_ovf));
        end
      end
    end else begin
      prev_rd = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [15:0] v);
    qa.push_back(v);
    ma.push_back(v);
  endtask

  task automatic push_b(input logic [15:0] v);
    qb.push_back(v);
    mb.push_back(v);
  endtask

  task automatic clear_model();
    qa.delete(); qb.delete(); ma.delete(); mb.delete();
    outs.delete(); wr_times.delete();
    rd_cnt  = 0;
    wr_cnt  = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    full_out = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Bounded wait for the write counter to reach a target
  task automatic wait_wr(input int target, input int budget, input string name);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (wr_cnt < target) begin
      n_total++;
      $display("FAIL %s_timeout: got %0d writes, expected %0d", name, wr_cnt, target);
    end
  endtask

  function automatic logic [15:0] rand_tok();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'hFFFF;
      3: return 16'(($urandom_range(0, 7)));
      default: return 16'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_wrap;
    logic [15:0] exp_sat;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] exp_v;
    int n;
    int pa, pb;

    vecs[0] = '{16'h0003, 16'h0004, 16'h0007, 16'h0007, 1'b0};
    vecs[1] = '{16'h000A, 16'h0014, 16'h001E, 16'h001E, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 1'b1};
    vecs[3] = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 1'b1};
    vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0};
    vecs[5] = '{16'h4000, 16'h4000, 16'h8000, 16'h7FFF, 1'b1};
    vecs[6] = '{16'h1234, 16'h0001, 16'h1235, 16'h1235, 1'b0};

    // --- Reset state and idle with empty FIFOs ---
    do_reset();
    check("reset_rd_a", 32'(rd_a), 32'd0);
    check("reset_wr_out", 32'(wr_out), 32'd0);
    repeat (20) tick();
    check("idle_rd_count", 32'(rd_cnt), 32'd0);
    check("idle_wr_count", 32'(wr_cnt), 32'd0);
    check("idle_token_cnt", 32'(token_cnt), 32'd0);
    check("idle_data_out", 32'(data_out), 32'd0);
    check("idle_ovf", 32'(ovf), 32'd0);

    // --- Two tokens back to back: 3+4, 10+20 ---
    push_a(16'd3); push_a(16'd10);
    push_b(16'd4); push_b(16'd20);
    wait_wr(2, 40, "two_tokens");
    tick();
    if (outs.size() == 2) begin
      check("two_tok_first", 32'(outs[0]), 32'd7);
      check("two_tok_second", 32'(outs[1]), 32'd30);
      check("two_tok_spacing", 32'(wr_times[1] - wr_times[0]), 32'd4);
    end
    check("two_tok_token_cnt", 32'(token_cnt), 32'd2);
    check("two_tok_rd_count", 32'(rd_cnt), 32'd2);

    // --- Reset during CAPTURE drops the in-flight token ---
    push_a(16'd100); push_b(16'd200);
    n = 0;
    while (!rd_a && n < 20) begin @(negedge clk); n++; end
    check("abort_saw_read", 32'(rd_a), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_rd_a", 32'(rd_a), 32'd0);
    check("abort_wr_out", 32'(wr_out), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    check("abort_token_cnt", 32'(token_cnt), 32'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) tick();
    check("abort_no_write", 32'(wr_cnt), 32'd0);
    check("abort_no_read", 32'(rd_cnt), 32'd0);

    // --- Output full blocks reads; release lets READ start next cycle ---
    do_reset();
    full_out = 1'b1;
    push_a(16'd1000); push_b(16'hFFFF);
    repeat (10) tick();
    check("full_no_read", 32'(rd_cnt), 32'd0);
    full_out = 1'b0;
    @(negedge clk);
    check("full_release_still_idle", 32'(rd_a), 32'd0);
    @(negedge clk);
    check("full_release_read", 32'(rd_a), 32'd1);
    wait_wr(1, 10, "full_release");
    check("full_release_data", 32'(data_out), 32'd999);

    // --- A available, B empty: block, then B arrives ---
    do_reset();
    push_a(16'd9);
    repeat (10) tick();
    check("b_empty_no_read", 32'(rd_cnt), 32'd0);
    push_b(16'd5);
    wait_wr(1, 20, "b_late");
    check("b_late_data", 32'(data_out), 32'd14);
    repeat (6) tick();
    check("b_late_one_read", 32'(rd_cnt), 32'd1);
    check("b_late_one_write", 32'(wr_cnt), 32'd1);

    // --- Table of single-token vectors, each from reset ---
    for (int i = 0; i < 7; i++) begin
      do_reset();
      push_a(vecs[i].a);
      push_b(vecs[i].b);
      wait_wr(1, 20, $sformatf("vec%0d", i));
`ifdef KPN_ADD_SAT_EN
      exp_v = vecs[i].exp_sat;
`else
      exp_v = vecs[i].exp_wrap;
`endif
      check($sformatf("vec%0d_data", i), 32'(data_out), 32'(exp_v));
      check($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].exp_ovf));
      tick();
      check($sformatf("vec%0d_token_cnt", i), 32'(token_cnt), 32'd1);
    end

    // --- Randomized traffic with backpressure ---
    do_reset();
    pa = 0;
    pb = 0;
    for (int c = 0; c < 1200; c++) begin
      tick();
      if (pa < N_RAND && $urandom_range(0, 2) == 0) begin push_a(rand_tok()); pa++; end
      if (pb < N_RAND && $urandom_range(0, 2) == 0) begin push_b(rand_tok()); pb++; end
      full_out = ($urandom_range(0, 3) == 0);
    end
    full_out = 1'b0;
    while (pa < N_RAND) begin push_a(rand_tok()); pa++; end
    while (pb < N_RAND) begin push_b(rand_tok()); pb++; end
    wait_wr(N_RAND, 6 * N_RAND + 50, "random");
    repeat (4) tick();
    check("random_token_cnt", 32'(token_cnt), 32'(N_RAND));
    check("random_rd_count", 32'(rd_cnt), 32'(N_RAND));
    check("random_final_ovf", 32'(ovf), 32'(exp_ovf));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_kpn_add_node
`default_nettype wire

// File: doc/kpn_add_node.md
# kpn_add_node

Kahn-process-network compute node that consumes one token from each of two upstream token FIFOs, adds them, and produces one sum token into a downstream token FIFO. It sits between the 16-bit token FIFOs of the KPN fabric. It drives their `rd`/`wr` strobes directly and accounts for the FIFO's registered, one-cycle read latency. Blocking-read / blocking-write semantics are enforced through the FIFOs' `empty`/`full` status lines.

## Interface
- `B`, 16: token width in bits, shared by both inputs and the output.
- `SIGNED`, 1: 1 = two's-complement operands, 0 = unsigned operands.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `empty_a`  input  1  upstream FIFO A empty flag.
- `empty_b`  input  1  upstream FIFO B empty flag.
- `data_a`  input  B  FIFO A read data, valid the cycle after `rd_a`.
- `data_b`  input  B  FIFO B read data, valid the cycle after `rd_b`.
- `full_out`  input  1  downstream FIFO full flag.
- `rd_a`, `rd_b`  output  1  read strobes to FIFOs A and B; always asserted together.
- `wr_out`  output  1  write strobe to the downstream FIFO.
- `data_out`  output  B  sum token; stable whenever `wr_out`=1.
- `token_cnt`  output  16  number of sum tokens written; wraps modulo 2^16.
- `ovf`  output  1  sticky flag, set on any arithmetic overflow; cleared only by reset.

## Operation
- FSM states: IDLE, READ, CAPTURE, WRITE.
- IDLE: move to READ when `empty_a`=0, `empty_b`=0 and `full_out`=0, all sampled in the same cycle. Otherwise hold in IDLE (blocking).
- READ: `rd_a`=`rd_b`=1 for exactly one cycle, then go to CAPTURE.
- CAPTURE: register `data_a` + `data_b` into `data_out`, update `ovf`, then go to WRITE.
- WRITE: `wr_out`=1 for exactly one cycle, `token_cnt` increments, then return to IDLE.
- Arithmetic: B-bit result, computed in a B+1-bit internal sum.
  - Unsigned overflow: carry out of bit B-1.
  - Signed overflow: both operands have the same sign and the result sign differs.
- Without saturation (see Configuration), the result wraps modulo 2^B.
- A token is never dropped or duplicated: exactly one read pair per write.
- Status flags are consulted only in IDLE. This node is the sole reader of A/B and the sole writer of the output FIFO, so the flags cannot go stale between IDLE and WRITE.

## Timing
- Reset values: `rd_a`=`rd_b`=`wr_out`=0, `data_out`=0, `token_cnt`=0, `ovf`=0, state=IDLE.
- All outputs are registered; no combinational path exists from any input to any output.
- Minimum latency is 3 cycles from the IDLE cycle with inputs available to the `wr_out` cycle. Peak throughput is 1 token per 4 cycles.
- `data_a`/`data_b` are sampled only at the end of CAPTURE, i.e. one cycle after the edge that sampled `rd`.
- Reset asserted mid-operation returns the node to IDLE immediately with strobes low.
  - A token already read but not yet written is lost. This is accepted; the whole network resets together.
- `full_out` rising during CAPTURE cannot occur because this node is the only writer.
- `token_cnt` wraps from 0xFFFF to 0x0000 without setting `ovf`.

## Configuration
- `KPN_ADD_SAT_EN` defined: on overflow the result saturates.
  - Signed: 0x7FFF for positive overflow, 0x8000 for negative overflow.
  - Unsigned: 0xFFFF.
- `KPN_ADD_SAT_EN` undefined: the result wraps.
- `ovf` behaves identically in both builds.

## Structure
- Shared package `kpn_pkg`:
  - `KPN_WORD_W` = 16.
  - FSM state encoding typedef: IDLE=2'b00, READ=2'b01, CAPTURE=2'b10, WRITE=2'b11.
  - Saturation constants.
- Sub-module `kpn_sat_add`: combinational B-bit adder with `SIGNED` parameter, overflow output, and `KPN_ADD_SAT_EN`-controlled clamp. The node FSM instantiates it once.

## Test plan
- After reset, both FIFOs empty for 20 cycles -> strobes stay 0, `token_cnt`=0, `data_out`=0.
- A holds {3, 10}, B holds {4, 20} -> two writes with `data_out` 7 then 30, `wr_out` pulses 4 cycles apart, `token_cnt`=2.
- SIGNED=1, A=0x7FFF, B=0x0001 -> with `KPN_ADD_SAT_EN` `data_out`=0x7FFF; without it 0x8000. `ovf`=1 in both builds.
- `full_out`=1 while both inputs are non-empty -> no `rd_a`/`rd_b` pulses. Release `full_out` -> READ occurs the next cycle.
- A non-empty, B empty for 10 cycles, then B gets 5 with A=9 -> exactly one read pair, `data_out`=14.
- Assert `reset_n`=0 during CAPTURE -> outputs return to reset values asynchronously; no `wr_out` pulse afterwards until new tokens arrive.
